// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, runs the instruction-memory req/ready handshake and
// feeds {inst, pc, pred_pc} to ID through the IF/ID latch backed by a one-entry skid buffer.
module fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_inst,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pred_pc,
    output logic [1:0]      dbg_state
);

    // Handshake: once imem_req rises, imem_req and imem_addr hold until a posedge
    // samples imem_req & imem_ready (completion). imem_data is valid in that cycle only.
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t          state;
    logic            live;
    logic [XLEN-1:0] squash_addr;
    logic            skid_valid;
    logic [XLEN-1:0] skid_inst;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pred_pc;
    logic            done;

    // live delays the first request to the cycle after reset release.
    assign imem_req  = live && ((state != S_FETCH) || !skid_valid);
    // A squashed access keeps its old address while pc already points at the redirect target.
    assign imem_addr = (state == S_SQUASH) ? squash_addr : pc;
    assign done      = imem_req && imem_ready;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_FETCH;
            live          <= 1'b0;
            pc            <= RESET_PC;
            squash_addr   <= '0;
            skid_valid    <= 1'b0;
            skid_inst     <= '0;
            skid_pc       <= '0;
            skid_pred_pc  <= '0;
            if_id_valid   <= 1'b0;
            if_id_inst    <= '0;
            if_id_pc      <= '0;
            if_id_pred_pc <= '0;
        end else begin
            live <= 1'b1;
            if (redirect) begin
                pc          <= redirect_pc;
                if_id_valid <= 1'b0;
                skid_valid  <= 1'b0;
                if (imem_req && !imem_ready) begin
                    state <= S_SQUASH;
                    if (state != S_SQUASH) begin
                        squash_addr <= pc;
                    end
                end else begin
                    state <= S_FETCH;
                end
            end else begin
                case (state)
                    S_FETCH:  if (imem_req && !imem_ready) state <= S_WAIT;
                    S_WAIT:   if (imem_ready) state <= S_FETCH;
                    S_SQUASH: if (imem_ready) state <= S_FETCH;
                    default:  state <= S_FETCH;
                endcase

                if (done && (state != S_SQUASH)) begin
                    pc <= pred_pc;
                    if (stall) begin
                        skid_valid   <= 1'b1;
                        skid_inst    <= imem_data;
                        skid_pc      <= pc;
                        skid_pred_pc <= pred_pc;
                    end else begin
                        if_id_valid   <= 1'b1;
                        if_id_inst    <= imem_data;
                        if_id_pc      <= pc;
                        if_id_pred_pc <= pred_pc;
                    end
                end else if (!stall) begin
                    // No request is issued while the skid is full, so draining never races a completion.
                    if (skid_valid) begin
                        if_id_valid   <= 1'b1;
                        if_id_inst    <= skid_inst;
                        if_id_pc      <= skid_pc;
                        if_id_pred_pc <= skid_pred_pc;
                        skid_valid    <= 1'b0;
                    end else begin
                        if_id_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model (pending access, drop flag,
// skid queue, IF/ID record) predicts every output each cycle.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pred_pc;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_live;
    logic [31:0] m_pc;
    logic        m_busy;
    logic        m_drop;
    logic [31:0] m_drop_addr;
    entry_t      skid_q[$];
    logic        m_valid;
    entry_t      m_ifid;

    // BTB: a "taken branch" sits at every address whose bits [6:2] equal 4 (0x10 -> 0x40).
    function automatic logic [31:0] btb(input logic [31:0] a);
        return (a[6:2] == 5'h4) ? a + 32'h30 : a + 32'h4;
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    assign pred_pc   = btb(pc);
    assign imem_data = inst_of(imem_addr);

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pred_pc(pred_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_data(imem_data), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_pred_pc(if_id_pred_pc), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic exp_req();
        return m_live && (m_drop || m_busy || (skid_q.size() == 0));
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_drop ? m_drop_addr : m_pc;
    endfunction

    task automatic reset_model();
        m_live = 1'b0; m_pc = 32'h0; m_busy = 1'b0; m_drop = 1'b0; m_drop_addr = '0;
        skid_q.delete(); m_valid = 1'b0; m_ifid = '0;
    endtask

    // Advance the model by one clock using the inputs present at this posedge.
    task automatic model_step();
        logic   req;
        entry_t e;
        req = exp_req();
        if (redirect) begin
            if (req && !imem_ready) begin
                if (!m_drop) m_drop_addr = exp_addr();
                m_drop = 1'b1;
            end else begin
                m_drop = 1'b0;
            end
            m_busy = 1'b0; m_pc = redirect_pc; skid_q.delete(); m_valid = 1'b0;
        end else if (m_drop) begin
            if (imem_ready) m_drop = 1'b0;
            if (!stall) m_valid = 1'b0;
        end else if (req && imem_ready) begin
            e.inst = inst_of(m_pc); e.pc = m_pc; e.pred = btb(m_pc);
            m_pc = e.pred; m_busy = 1'b0;
            if (stall) skid_q.push_back(e);
            else begin m_ifid = e; m_valid = 1'b1; end
        end else begin
            m_busy = req;
            if (!stall) begin
                if (skid_q.size() != 0) begin m_ifid = skid_q.pop_front(); m_valid = 1'b1; end
                else m_valid = 1'b0;
            end
        end
        m_live = 1'b1;
    endtask

    task automatic check_outputs();
        check("req", {31'b0, imem_req}, {31'b0, exp_req()});
        if (exp_req()) check("addr", imem_addr, exp_addr());
        check("pc", pc, m_pc);
        check("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("inst", if_id_inst, m_ifid.inst);
            check("ifid_pc", if_id_pc, m_ifid.pc);
            check("ifid_pred", if_id_pred_pc, m_ifid.pred);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_inst"}, if_id_inst, 32'h0);
        check({tag, "_ifid_pc"}, if_id_pc, 32'h0);
        check({tag, "_ifid_pred"}, if_id_pred_pc, 32'h0);
        check({tag, "_state"}, {30'b0, dbg_state}, 32'h0);
    endtask

    task automatic drive_random();
        imem_ready = ($urandom_range(0, 99) < 60);
        stall      = ($urandom_range(0, 99) < 25);
        redirect   = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8;
        else redirect_pc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    endtask

    task automatic drive_fixed(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
        imem_ready = rdy; stall = stl; redirect = rd; redirect_pc = rpc;
    endtask

    // One cycle: model consumes the inputs at posedge, new inputs follow, outputs checked at negedge.
    task automatic cycle(input int mode);
        @(posedge clk);
        model_step();
        #1;
        case (mode)
            0: drive_fixed(1'b1, 1'b0, 1'b0, 32'h0);
            1: drive_random();
            default: drive_fixed(1'b0, 1'b0, 1'b0, 32'h0);
        endcase
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset_model();
        drive_fixed(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b1;

        // Streaming with ready tied high, passing the BTB hit at 0x10.
        repeat (20) cycle(0);
        // Random ready/stall/redirect traffic.
        repeat (1500) cycle(1);

        // Redirect into the top of the address space, then stream across the wrap to 0.
        @(posedge clk); model_step(); #1;
        drive_fixed(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        @(negedge clk); check_outputs();
        repeat (6) cycle(0);

        // Hold ready low, then reset asynchronously in the middle of the wait.
        repeat (4) cycle(2);
        #2;
        reset = 1'b0;
        reset_model();
        #1;
        check_reset_state("async_reset");
        @(posedge clk); #1;
        drive_fixed(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_reset_state("held_reset");
        reset = 1'b1;

        repeat (10) cycle(0);
        repeat (800) cycle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
